// File: rtl/axi4_rd_resp_pkg.sv
// Shared constants, FSM encoding and burst address stepping for the AXI4 read responder.
package axi4_rd_resp_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // For WRAP, len is 2^k-1, so it doubles as the mask of the wrapping bits.
    function automatic logic [63:0] next_word_addr(input logic [63:0] addr,
                                                   input logic [7:0]  len,
                                                   input logic [1:0]  burst);
        logic [63:0] mask;
        logic [63:0] nxt;
        mask = {56'd0, len};
        case (burst)
            BURST_FIXED: nxt = addr;
            BURST_WRAP:  nxt = (addr & ~mask) | ((addr + 64'd1) & mask);
            default:     nxt = addr + 64'd1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/axi4_rd_responder_if.sv
// AXI4 read address and read data channels between a master and the responder.
interface axi4_rd_responder_if #(
    parameter int IDSIZE = 4,
    parameter int ASIZE  = 32,
    parameter int DSIZE  = 32,
    parameter int LSIZE  = 8
) ();
    logic [IDSIZE-1:0] s_arid;
    logic [ASIZE-1:0]  s_araddr;
    logic [LSIZE-1:0]  s_arlen;
    logic [2:0]        s_arsize;
    logic [1:0]        s_arburst;
    logic              s_arvalid;
    logic              s_arready;
    logic [IDSIZE-1:0] s_rid;
    logic [DSIZE-1:0]  s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;
    logic              s_rvalid;
    logic              s_rready;

    modport master (
        output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
        input  s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid
    );

    modport slave (
        input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
        output s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid
    );
endinterface

// File: rtl/axi4_rd_resp_fifo.sv
// Two-entry first-word-fall-through FIFO holding returned R beats.
module axi4_rd_resp_fifo #(
    parameter int W = 35
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    // NOTE: the storage is reset too, because the head drives the bus directly and must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;
endmodule

// File: rtl/axi4_rd_responder.sv
// AXI4 read responder: accepts one AR burst at a time, reads local memory per beat, returns R beats.
module axi4_rd_responder
    import axi4_rd_resp_pkg::*;
#(
    parameter int IDSIZE = 4,
    parameter int ASIZE  = 32,
    parameter int DSIZE  = 32,
    parameter int LSIZE  = 8,
    parameter int MEM_AW = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi4_rd_responder_if.slave   s_axi,
    output logic                 mem_rd_en_o,
    output logic [MEM_AW-1:0]    mem_addr_o,
    input  logic [DSIZE-1:0]     mem_rdata_i
);
    localparam int OFF = $clog2(DSIZE / 8);
    localparam int FW  = DSIZE + 3;

    state_e              state_q, state_d;
    logic                ready_en_q;
    logic [IDSIZE-1:0]   id_q;
    logic [1:0]          burst_q;
    logic [LSIZE-1:0]    len_q;
    logic                err_q;
    logic [MEM_AW-1:0]   addr_q;
    logic [LSIZE:0]      left_q;
    logic                pend_q, pend_last_q, pend_err_q;

    logic                ar_hs, ar_err, r_pop, issue, last_issue;
    logic [63:0]         ar_word, ar_hi_word;
    logic [1:0]          fifo_count;
    logic [2:0]          occupancy;
    logic [FW-1:0]       fifo_wdata, fifo_rdata;

    // Decode the incoming request and flag anything this memory cannot serve.
    assign ar_word = 64'(s_axi.s_araddr) >> OFF;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        ar_hi_word = ar_word;
        case (s_axi.s_arburst)
            BURST_INCR: ar_hi_word = ar_word + 64'(s_axi.s_arlen);
            BURST_WRAP: ar_hi_word = ar_word | 64'(s_axi.s_arlen);
            default:    ar_hi_word = ar_word;
        endcase
        ar_err = (s_axi.s_arsize != 3'(OFF))
              || (s_axi.s_arburst == BURST_RSVD)
              || ((s_axi.s_arburst == BURST_WRAP)
                  && (s_axi.s_arlen != LSIZE'(1)) && (s_axi.s_arlen != LSIZE'(3))
                  && (s_axi.s_arlen != LSIZE'(7)) && (s_axi.s_arlen != LSIZE'(15)))
              || ((ar_word >> MEM_AW) != 64'd0)
              || ((ar_hi_word >> MEM_AW) != 64'd0);
    end

    assign ar_hs      = s_axi.s_arvalid && s_axi.s_arready;
    assign r_pop      = s_axi.s_rvalid && s_axi.s_rready;
    // A beat leaving this cycle frees its slot for the read issued this cycle.
    assign occupancy  = 3'(fifo_count) + 3'(pend_q) - 3'(r_pop);
    assign last_issue = issue && (left_q == (LSIZE+1)'(1));

    // State register
    // NOTE: sequential state is always updated with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ar_hs) state_d = ST_RUN;
            ST_RUN:   if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (r_pop && s_axi.s_rlast) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        s_axi.s_arready = ready_en_q && (state_q == ST_IDLE);
        issue           = (state_q == ST_RUN) && (occupancy < 3'd2);
        mem_rd_en_o     = issue && !err_q;
        mem_addr_o      = addr_q;
    end

    // Burst bookkeeping and the one-cycle memory read pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q        <= '0;
            burst_q     <= BURST_FIXED;
            len_q       <= '0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            left_q      <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            pend_err_q  <= 1'b0;
        end else begin
            if (ar_hs) begin
                id_q    <= s_axi.s_arid;
                burst_q <= s_axi.s_arburst;
                len_q   <= s_axi.s_arlen;
                err_q   <= ar_err;
                addr_q  <= ar_word[MEM_AW-1:0];
                left_q  <= {1'b0, s_axi.s_arlen} + (LSIZE+1)'(1);
            end else if (issue) begin
                addr_q  <= MEM_AW'(next_word_addr(64'(addr_q), 8'(len_q), burst_q));
                left_q  <= left_q - (LSIZE+1)'(1);
            end
            pend_q      <= issue;
            pend_last_q <= last_issue;
            pend_err_q  <= err_q;
        end
    end

    assign fifo_wdata = {pend_err_q ? '0 : mem_rdata_i,
                         pend_err_q ? RESP_SLVERR : RESP_OKAY,
                         pend_last_q};

    axi4_rd_resp_fifo #(.W(FW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (pend_q),
        .wdata_i (fifo_wdata),
        .pop_i   (r_pop),
        .rdata_o (fifo_rdata),
        .valid_o (s_axi.s_rvalid),
        .count_o (fifo_count)
    );

    assign s_axi.s_rdata = fifo_rdata[FW-1:3];
    assign s_axi.s_rresp = fifo_rdata[2:1];
    assign s_axi.s_rlast = fifo_rdata[0];
    assign s_axi.s_rid   = id_q;
endmodule
